ram_arbiter: RTL and testbench

- Two-port arbiter sharing the single-port synchronous RAM between the CPU core (port 0) and a debug/loader master (port 1).
- The debug master is the button-driven memory inspector/loader.
- Uses a valid/ready-style request/grant handshake per port and a registered RAM command stage.
- Returns tagged read data to the port that issued each read.
- Sits between Core/debug logic and RAM in the cpu top level.

---
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: the CPU core is port 0
// and the debug/loader master is port 1. The RAM command is registered, and read data is returned to the port that issued the read.
module ram_arbiter #(
  parameter int AddrWidth   = 9,
  parameter int DataWidth   = 8,
  parameter int Policy      = 1,
  parameter int StarveLimit = 8
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req0,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [DataWidth-1:0] wdata0,
  input  logic                 we0,
  output logic                 gnt0,
  output logic [DataWidth-1:0] rdata0,
  output logic                 rvalid0,

  input  logic                 req1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wdata1,
  input  logic                 we1,
  output logic                 gnt1,
  output logic [DataWidth-1:0] rdata1,
  output logic                 rvalid1,

  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [DataWidth-1:0] mem_rdata
);

  localparam bit         RoundRobin = (Policy == 1);
  localparam logic [7:0] StarveMax  = 8'(StarveLimit);

  // Tag that follows each RAM command down the pipe; rd=0 means no read in flight.
  typedef struct packed {
    logic rd;
    logic port;
  } tag_t;

  localparam tag_t TagNone = '{rd: 1'b0, port: 1'b0};

  logic                 last_q, last_d;
  logic [7:0]           starve_cnt_q, starve_cnt_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  tag_t                 tag1_q, tag1_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;

  logic accept0;
  logic accept1;

  // Grant decision is purely combinational so a lone requester is accepted in its first cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves a signal unassigned would infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case ({req1, req0})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        if (RoundRobin) begin
          if (last_q) gnt0 = 1'b1;
          else        gnt1 = 1'b1;
        end else begin
          if (starve_cnt_q >= StarveMax) gnt1 = 1'b1;
          else                           gnt0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign accept0 = req0 & gnt0;
  assign accept1 = req1 & gnt1;

  always_comb begin
    last_d       = last_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    tag1_d       = TagNone;

    if (accept1)      last_d = 1'b1;
    else if (accept0) last_d = 1'b0;

    // The starvation counter only matters under fixed priority; it saturates at the limit.
    if (RoundRobin || !req1 || accept1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    if (accept1) begin
      mem_addr_d  = addr1;
      mem_wdata_d = wdata1;
      mem_we_d    = we1;
      tag1_d      = '{rd: ~we1, port: 1'b1};
    end else if (accept0) begin
      mem_addr_d  = addr0;
      mem_wdata_d = wdata0;
      mem_we_d    = we0;
      tag1_d      = '{rd: ~we0, port: 1'b0};
    end

    // Stage-2 tag is the rvalid pair itself: it lines up with RAM data one edge later.
    rvalid0_d = tag1_q.rd & ~tag1_q.port;
    rvalid1_d = tag1_q.rd &  tag1_q.port;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q       <= 1'b1;
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      tag1_q       <= TagNone;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the pre-edge value of the others, independent of statement order.
      last_q       <= last_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      tag1_q       <= tag1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? mem_rdata : '0;
  assign rdata1  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 is round-robin, instance 1 fixed priority with
// StarveLimit=4. Each drives its own RAM model; a scoreboard checks returned reads.
module tb_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;

  logic          req0   [2];
  logic [AW-1:0] addr0  [2];
  logic [DW-1:0] wdata0 [2];
  logic          we0    [2];
  logic          gnt0   [2];
  logic [DW-1:0] rdata0 [2];
  logic          rvalid0[2];
  logic          req1   [2];
  logic [AW-1:0] addr1  [2];
  logic [DW-1:0] wdata1 [2];
  logic          we1    [2];
  logic          gnt1   [2];
  logic [DW-1:0] rdata1 [2];
  logic          rvalid1[2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata[2];
  logic          mem_we   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t sb0[$];
  exp_t sb1[$];
  int   glog[$];
  logic [DW-1:0] shadow [2][1<<AW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ {a[8], 7'h33};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] ram_rdata;

    ram_arbiter #(
      .AddrWidth  (AW),
      .DataWidth  (DW),
      .Policy     ((g == 0) ? 1 : 0),
      .StarveLimit(4)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0[g]),
      .addr0    (addr0[g]),
      .wdata0   (wdata0[g]),
      .we0      (we0[g]),
      .gnt0     (gnt0[g]),
      .rdata0   (rdata0[g]),
      .rvalid0  (rvalid0[g]),
      .req1     (req1[g]),
      .addr1    (addr1[g]),
      .wdata1   (wdata1[g]),
      .we1      (we1[g]),
      .gnt1     (gnt1[g]),
      .rdata1   (rdata1[g]),
      .rvalid1  (rvalid1[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_we   (mem_we[g]),
      .mem_rdata(ram_rdata)
    );

    // Single-port synchronous RAM, read-first, data one cycle after the address edge.
    always @(posedge clk) begin
      if (ram_init) begin
        for (int a = 0; a < (1 << AW); a++) ram[a] <= init_val(AW'(a));
      end else begin
        if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
        ram_rdata <= ram[mem_addr[g]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    return c;
  endfunction

  task automatic drive(input int inst);
    if (q0.size() != 0) begin
      req0[inst] = 1'b1; we0[inst] = q0[0].we; addr0[inst] = q0[0].addr; wdata0[inst] = q0[0].wdata;
    end else begin
      req0[inst] = 1'b0;
    end
    if (q1.size() != 0) begin
      req1[inst] = 1'b1; we1[inst] = q1[0].we; addr1[inst] = q1[0].addr; wdata1[inst] = q1[0].wdata;
    end else begin
      req1[inst] = 1'b0;
    end
  endtask

  task automatic accept_cmd(input int inst, input int port, input cmd_t c);
    exp_t e;
    if (c.we) begin
      shadow[inst][c.addr] = c.wdata;
    end else begin
      e.port = port;
      e.data = shadow[inst][c.addr];
      e.cyc  = cyc + 2;
      if (inst == 0) sb0.push_back(e);
      else           sb1.push_back(e);
    end
  endtask

  // Presents queued commands on both ports until all are accepted; logs the granted port per cycle.
  task automatic run_cmds(input int inst, input int budget);
    int n = 0;
    logic g0, g1, r0, r1;
    glog.delete();
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      drive(inst);
      @(negedge clk);
      g0 = gnt0[inst]; g1 = gnt1[inst]; r0 = req0[inst]; r1 = req1[inst];
      check("single_grant", 32'(g0 & g1), 32'd0);
      check("grant_needs_req", 32'((g0 & ~r0) | (g1 & ~r1)), 32'd0);
      if (r0 && g0) begin
        glog.push_back(0);
        accept_cmd(inst, 0, q0.pop_front());
      end else if (r1 && g1) begin
        glog.push_back(1);
        accept_cmd(inst, 1, q1.pop_front());
      end else begin
        glog.push_back(-1);
      end
      @(posedge clk); #1;
      n++;
    end
    check("cmds_drained", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    req0[inst] = 1'b0;
    req1[inst] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sb0.delete();
    sb1.delete();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding read of that instance.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rvalid0[i] || rvalid1[i]) begin
        check($sformatf("one_rvalid[%0d]", i), 32'(rvalid0[i] & rvalid1[i]), 32'd0);
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid[%0d]: got rvalid0=%0d rvalid1=%0d expected none (t=%0t)",
                   i, rvalid0[i], rvalid1[i], $time);
        end else begin
          mon_e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("rvalid_port[%0d]", i), 32'(rvalid1[i]), mon_e.port);
          check($sformatf("rdata[%0d]", i), 32'(rvalid1[i] ? rdata1[i] : rdata0[i]), 32'(mon_e.data));
          check($sformatf("idle_rdata[%0d]", i), 32'(rvalid1[i] ? rdata0[i] : rdata1[i]), 32'd0);
          check($sformatf("read_latency[%0d]", i), cyc, mon_e.cyc);
        end
      end
    end
  end

  // A waiting requester must hold its command stable until accepted.
  function automatic logic [18:0] req_word(input int i, input int p);
    return (p == 0) ? {req0[i], we0[i], addr0[i], wdata0[i]} : {req1[i], we1[i], addr1[i], wdata1[i]};
  endfunction

  logic [18:0] prev_cmd [2][2];
  logic        prev_gnt [2][2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (prev_cmd[i][p][18] === 1'b1 && prev_gnt[i][p] === 1'b0 && req_word(i, p) !== prev_cmd[i][p]
            && req_word(i, p)[18] === 1'b1) begin
          total++;
          bad++;
          $display("FAIL protocol_hold[%0d][%0d]: got 0x%0h expected 0x%0h", i, p, req_word(i, p), prev_cmd[i][p]);
        end
        prev_cmd[i][p] <= req_word(i, p);
        prev_gnt[i][p] <= (p == 0) ? gnt0[i] : gnt1[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    ram_init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0; we0[i] = 1'b0;
      req1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0; we1[i] = 1'b0;
      for (int a = 0; a < (1 << AW); a++) shadow[i][a] = init_val(AW'(a));
    end

    // Reset held 3 cycles, then 10 idle cycles.
    @(posedge clk);
    #1 ram_init = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("idle_mem_we[%0d]", i), 32'(mem_we[i]), 32'd0);
        check($sformatf("idle_mem_addr[%0d]", i), 32'(mem_addr[i]), 32'd0);
        check($sformatf("idle_gnt0[%0d]", i), 32'(gnt0[i]), 32'd0);
        check($sformatf("idle_gnt1[%0d]", i), 32'(gnt1[i]), 32'd0);
        check($sformatf("idle_rvalid0[%0d]", i), 32'(rvalid0[i]), 32'd0);
        check($sformatf("idle_rvalid1[%0d]", i), 32'(rvalid1[i]), 32'd0);
      end
    end
    @(posedge clk); #1;

    // Port 1 alone: write 0x5A to 0x123, then read it back.
    q1.push_back(mk(1'b1, 9'h123, 8'h5A));
    run_cmds(0, 20);
    check("wr_gnt_count", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) check("wr_gnt_port", glog[0], 1);
    check("wr_mem_we", 32'(mem_we[0]), 32'd1);
    check("wr_mem_addr", 32'(mem_addr[0]), 32'h123);
    check("wr_mem_wdata", 32'(mem_wdata[0]), 32'h5A);
    q1.push_back(mk(1'b0, 9'h123, 8'h00));
    run_cmds(0, 20);
    if (glog.size() > 0) check("rd_gnt_port", glog[0], 1);
    idle(4);

    // Round-robin contention from reset: grants alternate starting with port 0.
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      q0.push_back(mk(1'b0, AW'(k), 8'h00));
      q1.push_back(mk(1'b0, AW'(9'h100 + k), 8'h00));
    end
    run_cmds(0, 60);
    check("rr_accepts", 32'(glog.size()), 32'd20);
    for (int k = 0; k < glog.size(); k++) check($sformatf("rr_gnt_%0d", k), glog[k], k % 2);
    idle(4);

    // Fixed priority, StarveLimit=4: four port-0 accepts then one port-1 accept.
    for (int k = 0; k < 12; k++) q0.push_back(mk(1'b0, AW'(k), 8'h00));
    for (int k = 0; k < 3; k++)  q1.push_back(mk(1'b0, AW'(9'h100 + k), 8'h00));
    run_cmds(1, 60);
    check("fp_accepts", 32'(glog.size()), 32'd15);
    for (int k = 0; k < glog.size(); k++) check($sformatf("fp_gnt_%0d", k), glog[k], (k % 5 == 4) ? 1 : 0);
    idle(4);

    // Port 0 writes 0xC3 to 0x010; port 1 reads it on the very next accept.
    do_reset(2);
    q0.push_back(mk(1'b1, 9'h010, 8'hC3));
    q1.push_back(mk(1'b0, 9'h010, 8'h00));
    run_cmds(0, 20);
    check("wtr_accepts", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("wtr_first", glog[0], 0);
      check("wtr_second", glog[1], 1);
    end
    check("wtr_shadow", 32'(shadow[0][9'h010]), 32'hC3);
    idle(4);

    // Reset the cycle after a port 0 read accept: the read must never return.
    q0.push_back(mk(1'b0, 9'h030, 8'h00));
    run_cmds(0, 20);
    reset = 1'b1;
    sb0.delete();
    #1 check("rst_rd_mem_we", 32'(mem_we[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_rd_rvalid0", 32'(rvalid0[0]), 32'd0);
    end
    @(posedge clk); #1;

    // Reset right after a write accept: mem_we drops at once and the write is lost.
    q0.push_back(mk(1'b1, 9'h020, 8'hEE));
    run_cmds(0, 20);
    check("rst_wr_mem_we_before", 32'(mem_we[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr_mem_we_async", 32'(mem_we[0]), 32'd0);
    check("rst_wr_mem_addr_async", 32'(mem_addr[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    shadow[0][9'h020] = init_val(9'h020);
    q0.push_back(mk(1'b0, 9'h020, 8'h00));
    run_cmds(0, 20);
    idle(6);

    check("sb0_empty", 32'(sb0.size()), 32'd0);
    check("sb1_empty", 32'(sb1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
